ram_stream_reader: RTL and testbench



---
 rtl/ram_stream_reader.sv | 169 ++++++++++++++++
 tb/tb_ram_stream_reader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Burst read master for one block-RAM port.
// Turns a (start, length) command into sequential reads and a valid/ready word stream.

// Four-entry word buffer with registered storage; the head is visible the cycle after its push.
// There is no overflow guard: the producer's credit rule keeps occupancy at 3 or below.
module ram_stream_reader_fifo #(
    parameter int W = 32
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_vld_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_rdy_i,
    output logic         pop_vld_o,
    output logic [W-1:0] pop_dat_o,
    output logic [2:0]   count_o
);
    logic [W-1:0] mem_q [4];
    logic [1:0]   wr_ptr_q;
    logic [1:0]   rd_ptr_q;
    logic [2:0]   count_q;
    logic         pop;

    assign pop_vld_o = (count_q != 3'd0);
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign pop       = pop_vld_o & pop_rdy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
        end else begin
            if (push_vld_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= wr_ptr_q + 2'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 2'd1;
            end
            case ({push_vld_i, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule

// Start sampled in cycle 0 -> first read in cycle 1 -> first word valid in cycle 3; 1 word/cycle sustained.
// Reads stop when buffered plus in-flight words would exceed the buffer's spare room.
module ram_stream_reader #(
    parameter int  Width = 32,
    parameter int  Depth = 1024,
    localparam int AW    = $clog2(Depth)
) (
    input  logic             ipClk,
    input  logic             ipReset,
    input  logic             ipStart,
    input  logic [AW-1:0]    ipStartAddress,
    input  logic [AW:0]      ipLength,
    output logic             opBusy,
    output logic             opDone,
    output logic             opRamClkEnable,
    output logic [AW-1:0]    opRamAddress,
    input  logic [Width-1:0] ipRamRdData,
    output logic [Width-1:0] opData,
    output logic             opValid,
    input  logic             ipReady
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

    localparam logic [AW-1:0] LastAddr = AW'(Depth - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   left_q, left_d;
    logic          inflight_q, inflight_d;
    logic          done_q, done_d;
    logic          issue;
    logic          pop;
    logic [2:0]    fifo_count;
    logic          credit_ok;

    assign pop       = opValid & ipReady;
    // An in-flight read lands in the buffer next cycle, so it already holds a slot.
    assign credit_ok = (fifo_count + {2'b00, inflight_q}) <= 3'd2;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        left_d     = left_q;
        done_d     = 1'b0;
        issue      = 1'b0;
        case (state_q)
            IDLE: begin
                if (ipStart) begin
                    if (ipLength != '0) begin
                        addr_d  = ipStartAddress;
                        left_d  = ipLength;
                        state_d = READ;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            READ: begin
                if ((left_q != '0) && credit_ok) begin
                    issue  = 1'b1;
                    addr_d = (addr_q == LastAddr) ? '0 : addr_q + AW'(1);
                    left_d = left_q - (AW+1)'(1);
                    if (left_q == (AW+1)'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && !inflight_q && (fifo_count == 3'd1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        inflight_d = issue;
    end

    always_ff @(posedge ipClk or posedge ipReset) begin
        if (ipReset) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    ram_stream_reader_fifo #(
        .W (Width)
    ) u_fifo (
        .clk_i      (ipClk),
        .rst_i      (ipReset),
        .push_vld_i (inflight_q),
        .push_dat_i (ipRamRdData),
        .pop_rdy_i  (ipReady),
        .pop_vld_o  (opValid),
        .pop_dat_o  (opData),
        .count_o    (fifo_count)
    );

    assign opBusy         = (state_q != IDLE);
    assign opDone         = done_q;
    assign opRamClkEnable = issue;
    assign opRamAddress   = addr_q;
endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed and randomized-backpressure bench for ram_stream_reader with behavioural RAM models.
module tb_ram_stream_reader;
    logic        ipClk = 1'b0;
    logic        ipReset;
    logic        ipStart;
    logic [9:0]  ipStartAddress;
    logic [10:0] ipLength;
    logic        opBusy, opDone, opRamClkEnable, opValid, ipReady;
    logic [9:0]  opRamAddress;
    logic [31:0] ipRamRdData, opData;

    logic        w_start, w_busy, w_done, w_en, w_valid, w_ready;
    logic [3:0]  w_addr, w_raddr;
    logic [4:0]  w_len;
    logic [31:0] w_rd, w_data;

    logic [31:0] ram1k [1024];
    logic [31:0] ram16 [16];
    logic [31:0] got [$];
    logic [31:0] w_got [$];
    logic [3:0]  w_iss [$];

    int errors, checks, done_cnt, iss_cnt;
    int b_got, b_done, b_iss, n, bad, addr, len;
    bit rand_rdy;

    always #5 ipClk = ~ipClk;

    ram_stream_reader #(.Width(32), .Depth(1024)) u_dut (
        .ipClk(ipClk), .ipReset(ipReset), .ipStart(ipStart),
        .ipStartAddress(ipStartAddress), .ipLength(ipLength),
        .opBusy(opBusy), .opDone(opDone), .opRamClkEnable(opRamClkEnable),
        .opRamAddress(opRamAddress), .ipRamRdData(ipRamRdData),
        .opData(opData), .opValid(opValid), .ipReady(ipReady)
    );

    ram_stream_reader #(.Width(32), .Depth(16)) u_wrap (
        .ipClk(ipClk), .ipReset(ipReset), .ipStart(w_start),
        .ipStartAddress(w_addr), .ipLength(w_len),
        .opBusy(w_busy), .opDone(w_done), .opRamClkEnable(w_en),
        .opRamAddress(w_raddr), .ipRamRdData(w_rd),
        .opData(w_data), .opValid(w_valid), .ipReady(w_ready)
    );

    // Read port with one-cycle latency; output holds when the clock enable is low.
    always @(posedge ipClk) begin
        if (opRamClkEnable) ipRamRdData <= ram1k[opRamAddress];
        if (w_en) w_rd <= ram16[w_raddr];
    end

    always @(negedge ipClk) begin
        if (opValid && ipReady) got.push_back(opData);
        if (opDone) done_cnt++;
        if (opRamClkEnable) iss_cnt++;
        if (w_valid && w_ready) w_got.push_back(w_data);
        if (w_en) w_iss.push_back(w_raddr);
    end

    task automatic step();
        @(posedge ipClk);
        #1;
        if (rand_rdy) ipReady = 1'($urandom_range(0, 1));
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int target, input int limit);
        int k = 0;
        while (done_cnt < target && k < limit) begin
            step();
            k++;
        end
        check1("done_timeout", done_cnt >= target, 1'b1);
    endtask

    initial begin
        errors = 0; checks = 0; done_cnt = 0; iss_cnt = 0; rand_rdy = 0;
        ipReset = 1; ipStart = 0; ipStartAddress = '0; ipLength = '0; ipReady = 0;
        w_start = 0; w_addr = '0; w_len = '0; w_ready = 1;
        ipRamRdData = '0; w_rd = '0;
        for (int i = 0; i < 1024; i++) ram1k[i] = 32'h5A00_0000 ^ (32'(i) * 32'h0001_9E37);
        for (int i = 0; i < 4; i++) ram1k[10 + i] = 32'hA0 + 32'(i);
        for (int i = 0; i < 16; i++) ram16[i] = 32'h1600_0000 + 32'(i);
        step(); step();

        check1("rst_busy", opBusy, 1'b0);
        check1("rst_done", opDone, 1'b0);
        check1("rst_valid", opValid, 1'b0);
        check1("rst_en", opRamClkEnable, 1'b0);
        check32("rst_addr", 32'(opRamAddress), 32'd0);
        check32("rst_data", opData, 32'd0);
        ipReset = 0;
        step();

        // Basic burst, cycle 0 is this cycle.
        ipStart = 1; ipStartAddress = 10'd10; ipLength = 11'd4; ipReady = 1;
        for (int c = 1; c <= 8; c++) begin
            step();
            ipStart = 0;
            check1("basic_en", opRamClkEnable, c >= 1 && c <= 4);
            if (c <= 4) check32("basic_addr", 32'(opRamAddress), 32'(10 + c - 1));
            check1("basic_valid", opValid, c >= 3 && c <= 6);
            if (c >= 3 && c <= 6) check32("basic_data", opData, 32'hA0 + 32'(c - 3));
            check1("basic_done", opDone, c == 7);
            check1("basic_busy", opBusy, c >= 1 && c <= 6);
        end

        // Zero length.
        ipStart = 1; ipStartAddress = 10'd5; ipLength = 11'd0;
        for (int c = 1; c <= 5; c++) begin
            step();
            ipStart = 0;
            check1("zero_done", opDone, c == 1);
            check1("zero_busy", opBusy, 1'b0);
            check1("zero_valid", opValid, 1'b0);
            check1("zero_en", opRamClkEnable, 1'b0);
        end

        // Wrap-around on the 16-deep instance.
        w_start = 1; w_addr = 4'd14; w_len = 5'd4;
        step();
        w_start = 0;
        n = 0;
        while (w_done !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check1("wrap_timeout", n < 30, 1'b1);
        step();
        check32("wrap_niss", w_iss.size(), 32'd4);
        check32("wrap_nwords", w_got.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            int ea;
            ea = (14 + i) % 16;
            if (i < w_iss.size()) check32("wrap_addr", 32'(w_iss[i]), 32'(ea));
            if (i < w_got.size()) check32("wrap_data", w_got[i], ram16[ea]);
        end

        // Backpressure: ready low for cycles 0..9.
        b_got = got.size(); b_done = done_cnt; b_iss = iss_cnt;
        ipStart = 1; ipStartAddress = 10'd200; ipLength = 11'd8; ipReady = 0;
        for (int c = 1; c <= 9; c++) begin
            step();
            ipStart = 0;
            if (c >= 3) begin
                check1("bp_valid", opValid, 1'b1);
                check32("bp_hold", opData, ram1k[200]);
            end
        end
        step();
        check1("bp_issue_le3", (iss_cnt - b_iss) <= 3, 1'b1);
        check32("bp_no_accept", got.size() - b_got, 32'd0);
        ipReady = 1;
        wait_done(b_done + 1, 60);
        check32("bp_nwords", got.size() - b_got, 32'd8);
        for (int i = 0; i < 8; i++)
            if (b_got + i < got.size()) check32("bp_word", got[b_got + i], ram1k[200 + i]);

        // Start while busy is ignored.
        b_got = got.size(); b_done = done_cnt;
        ipStart = 1; ipStartAddress = 10'd300; ipLength = 11'd8;
        step();
        ipStart = 0;
        step(); step();
        ipStart = 1; ipStartAddress = 10'd100; ipLength = 11'd2;
        step();
        ipStart = 0;
        wait_done(b_done + 1, 60);
        for (int i = 0; i < 6; i++) step();
        check32("busy_ndone", done_cnt - b_done, 32'd1);
        check32("busy_nwords", got.size() - b_got, 32'd8);
        for (int i = 0; i < 8; i++)
            if (b_got + i < got.size()) check32("busy_word", got[b_got + i], ram1k[300 + i]);

        // Reset after three accepted words.
        b_got = got.size(); b_done = done_cnt;
        ipStart = 1; ipStartAddress = 10'd500; ipLength = 11'd8;
        step();
        ipStart = 0;
        n = 0;
        while (got.size() - b_got < 3 && n < 30) begin
            step();
            n++;
        end
        check1("rstmid_timeout", n < 30, 1'b1);
        ipReset = 1;
        #1;
        check1("rstmid_busy", opBusy, 1'b0);
        check1("rstmid_done", opDone, 1'b0);
        check1("rstmid_valid", opValid, 1'b0);
        check1("rstmid_en", opRamClkEnable, 1'b0);
        check32("rstmid_addr", 32'(opRamAddress), 32'd0);
        check32("rstmid_data", opData, 32'd0);
        step();
        check1("rstmid_valid2", opValid, 1'b0);
        ipReset = 0;
        check32("rstmid_nodone", done_cnt - b_done, 32'd0);
        b_got = got.size(); b_done = done_cnt;
        ipStart = 1; ipStartAddress = 10'd600; ipLength = 11'd2;
        step();
        ipStart = 0;
        wait_done(b_done + 1, 30);
        check32("post_nwords", got.size() - b_got, 32'd2);
        for (int i = 0; i < 2; i++)
            if (b_got + i < got.size()) check32("post_word", got[b_got + i], ram1k[600 + i]);

        // Random backpressure bursts against the scoreboard.
        rand_rdy = 1;
        for (int b = 0; b < 1000; b++) begin
            addr = int'($urandom_range(0, 1023));
            len = int'($urandom_range(1, 12));
            b_got = got.size(); b_done = done_cnt;
            ipStart = 1; ipStartAddress = 10'(addr); ipLength = 11'(len);
            step();
            ipStart = 0;
            wait_done(b_done + 1, 200);
            bad = 0;
            if (got.size() - b_got != len) bad++;
            for (int i = 0; i < len; i++)
                if (b_got + i < got.size() && got[b_got + i] !== ram1k[(addr + i) % 1024]) bad++;
            check32("rand_burst", 32'(bad), 32'd0);
        end
        rand_rdy = 0;
        ipReady = 1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
